// File: rtl/calc_sequencer_pkg.sv
// Shared encodings for the calculator sequencer: FSM state codes shown on the
// LEDs and the ALU operation codes driven by op_latched.
package calc_sequencer_pkg;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_OR  = 2'd3;

endpackage

// File: rtl/calc_sequencer_btn_cond.sv
// Push-button conditioner: two-flop synchronizer, level debounce counter and a
// single-cycle pulse on each accepted press (releases produce no pulse).
module btn_cond #(
  parameter logic [15:0] DB_CYCLES = 16'd50000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn,
  output logic pulse
);

  logic        sync1_reg;
  logic        sync2_reg;
  logic        stable_reg;
  logic        stable_d_reg;
  logic [15:0] cnt_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg    <= 1'b0;
      sync2_reg    <= 1'b0;
      stable_reg   <= 1'b0;
      stable_d_reg <= 1'b0;
      cnt_reg      <= 16'd0;
    end else begin
      sync1_reg    <= btn;
      sync2_reg    <= sync1_reg;
      stable_d_reg <= stable_reg;
      // Any cycle where the synchronized level agrees with the accepted one
      // restarts the hold count, so short glitches never get through.
      if (sync2_reg == stable_reg) begin
        cnt_reg <= 16'd0;
      end else if (cnt_reg == DB_CYCLES - 16'd1) begin
        stable_reg <= sync2_reg;
        cnt_reg    <= 16'd0;
      end else begin
        cnt_reg <= cnt_reg + 16'd1;
      end
    end
  end

  assign pulse = stable_reg & ~stable_d_reg;

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control FSM: steps through operand A, operand B, op select,
// execute and result display, issuing one-cycle register load pulses.
module calc_sequencer #(
  parameter logic [15:0] DB_CYCLES = 16'd50000,
  parameter logic [3:0]  ALU_LAT   = 4'd2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       btn_enter,
  input  logic       btn_clear,
  input  logic [1:0] op_sel,
  output logic       ld_a,
  output logic       ld_b,
  output logic       ld_r,
  output logic [1:0] op_latched,
  output logic       busy,
  output logic       done,
  output logic [2:0] state_code
);
  import calc_sequencer_pkg::*;

  logic       enter_p;
  logic       clear_p;
  state_t     state_reg, state_next;
  logic [3:0] lat_reg, lat_next;
  logic [1:0] op_next;
  logic       ld_a_next, ld_b_next, ld_r_next;

  btn_cond #(.DB_CYCLES(DB_CYCLES)) u_enter (
    .clock   (clock),
    .reset_n (reset_n),
    .btn     (btn_enter),
    .pulse   (enter_p)
  );

  btn_cond #(.DB_CYCLES(DB_CYCLES)) u_clear (
    .clock   (clock),
    .reset_n (reset_n),
    .btn     (btn_clear),
    .pulse   (clear_p)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= S_A;
      lat_reg    <= 4'd0;
      op_latched <= OP_ADD;
      ld_a       <= 1'b0;
      ld_b       <= 1'b0;
      ld_r       <= 1'b0;
    end else begin
      state_reg  <= state_next;
      lat_reg    <= lat_next;
      op_latched <= op_next;
      ld_a       <= ld_a_next;
      ld_b       <= ld_b_next;
      ld_r       <= ld_r_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    lat_next   = lat_reg;
    op_next    = op_latched;
    ld_a_next  = 1'b0;
    ld_b_next  = 1'b0;
    ld_r_next  = 1'b0;
    // Clear overrides everything, including a coincident enter press.
    if (clear_p) begin
      state_next = S_A;
      op_next    = OP_ADD;
      lat_next   = 4'd0;
    end else begin
      case (state_reg)
        S_A: begin
          if (enter_p) begin
            ld_a_next  = 1'b1;
            state_next = S_B;
          end
        end
        S_B: begin
          if (enter_p) begin
            ld_b_next  = 1'b1;
            state_next = S_OP;
          end
        end
        S_OP: begin
          if (enter_p) begin
            op_next    = op_sel;
            lat_next   = ALU_LAT - 4'd1;
            state_next = S_EXEC;
          end
        end
        S_EXEC: begin
          // enter presses here are deliberately dropped, not queued
          if (lat_reg == 4'd0) begin
            ld_r_next  = 1'b1;
            state_next = S_DONE;
          end else begin
            lat_next = lat_reg - 4'd1;
          end
        end
        S_DONE: begin
          if (enter_p) begin
            state_next = S_A;
          end
        end
        default: begin
          state_next = S_A;
          lat_next   = 4'd0;
        end
      endcase
    end
  end

  assign busy       = (state_reg == S_EXEC);
  assign done       = (state_reg == S_DONE);
  assign state_code = state_reg;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: expected load pulses are queued at
// stimulus time and a negedge monitor pops and compares each observed pulse.
module tb_calc_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       btn_enter, btn_clear;
  logic [1:0] op_sel;
  logic       ld_a, ld_b, ld_r, busy, done;
  logic [1:0] op_latched;
  logic [2:0] state_code;

  logic       enter8, clear8;
  logic [1:0] op_sel8;
  logic       ld_a8, ld_b8, ld_r8, busy8, done8;
  logic [1:0] op_latched8;
  logic [2:0] state_code8;

  always #5 clock = ~clock;

  calc_sequencer #(.DB_CYCLES(16'd4), .ALU_LAT(4'd2)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .btn_enter  (btn_enter),
    .btn_clear  (btn_clear),
    .op_sel     (op_sel),
    .ld_a       (ld_a),
    .ld_b       (ld_b),
    .ld_r       (ld_r),
    .op_latched (op_latched),
    .busy       (busy),
    .done       (done),
    .state_code (state_code)
  );

  calc_sequencer #(.DB_CYCLES(16'd4), .ALU_LAT(4'd8)) dut8 (
    .clock      (clock),
    .reset_n    (reset_n),
    .btn_enter  (enter8),
    .btn_clear  (clear8),
    .op_sel     (op_sel8),
    .ld_a       (ld_a8),
    .ld_b       (ld_b8),
    .ld_r       (ld_r8),
    .op_latched (op_latched8),
    .busy       (busy8),
    .done       (done8),
    .state_code (state_code8)
  );

  typedef struct packed {
    logic [2:0] ld;   // {ld_r, ld_b, ld_a}
    logic [1:0] op;
    logic [2:0] st;
  } exp_t;

  exp_t exp_q[$];
  exp_t got, want;
  int   checks = 0;
  int   errors = 0;
  int   busy_total = 0;
  int   ldr8_total = 0;

  function automatic exp_t mk(logic [2:0] ld, logic [1:0] op, logic [2:0] st);
    exp_t e;
    e.ld = ld;
    e.op = op;
    e.st = st;
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press_enter(int hold);
    btn_enter = 1'b1;
    tick(hold);
    btn_enter = 1'b0;
    tick(15);
  endtask

  task automatic drain(string name, int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) tick(1);
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Monitor: every load pulse must match the next queued expectation.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && (ld_a | ld_b | ld_r)) begin
      got = mk({ld_r, ld_b, ld_a}, op_latched, state_code);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual=%0h required=none", got);
      end else begin
        want = exp_q.pop_front();
        check("ld_pulse", 32'(got), 32'(want));
      end
    end
  end

  always @(negedge clock) begin
    if (busy) busy_total++;
    if (ld_r8) ldr8_total++;
  end

  initial begin
    #1000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int b0, r0;
    reset_n = 1'b0;
    btn_enter = 1'b0; btn_clear = 1'b0; op_sel = 2'd0;
    enter8 = 1'b0; clear8 = 1'b0; op_sel8 = 2'd2;
    tick(3);
    check("rst_state", 32'(state_code), 32'd0);
    check("rst_ld", 32'({ld_a, ld_b, ld_r}), 32'd0);
    check("rst_op", 32'(op_latched), 32'd0);
    check("rst_busy_done", 32'({busy, done}), 32'd0);
    reset_n = 1'b1;
    tick(2);

    // Full flow: A, B, op=SUB, execute, show, back to A
    exp_q.push_back(mk(3'b001, 2'd0, 3'd1));
    press_enter(8);
    drain("flow_ld_a", 5);
    check("flow_state_b", 32'(state_code), 32'd1);
    exp_q.push_back(mk(3'b010, 2'd0, 3'd2));
    press_enter(8);
    drain("flow_ld_b", 5);
    check("flow_state_op", 32'(state_code), 32'd2);
    op_sel = 2'd1;
    b0 = busy_total;
    exp_q.push_back(mk(3'b100, 2'd1, 3'd4));
    press_enter(8);
    op_sel = 2'd3;
    tick(5);
    drain("flow_ld_r", 5);
    check("flow_op", 32'(op_latched), 32'd1);
    check("flow_done", 32'(done), 32'd1);
    check("flow_state_done", 32'(state_code), 32'd4);
    check("flow_busy_cycles", 32'(busy_total - b0), 32'd2);
    press_enter(8);
    check("flow_back_a", 32'(state_code), 32'd0);
    check("flow_op_kept", 32'(op_latched), 32'd1);
    check("flow_done_low", 32'(done), 32'd0);

    // Glitch shorter than the debounce window is ignored
    press_enter(3);
    check("glitch_state", 32'(state_code), 32'd0);
    // 10-cycle press: one ld_a within DB_CYCLES+5 cycles
    exp_q.push_back(mk(3'b001, 2'd1, 3'd1));
    btn_enter = 1'b1;
    tick(9);
    check("ld_a_latency", 32'(exp_q.size()), 32'd0);
    tick(1);
    btn_enter = 1'b0;
    tick(15);
    drain("press10_ld_a", 1);
    check("press10_state", 32'(state_code), 32'd1);

    // Clear from S_B
    btn_clear = 1'b1;
    tick(8);
    btn_clear = 1'b0;
    tick(15);
    check("clear_state", 32'(state_code), 32'd0);
    check("clear_op", 32'(op_latched), 32'd0);

    // Held button: a single ld_a
    exp_q.push_back(mk(3'b001, 2'd0, 3'd1));
    btn_enter = 1'b1;
    tick(200);
    btn_enter = 1'b0;
    tick(15);
    drain("held_ld_a", 1);
    check("held_state", 32'(state_code), 32'd1);

    // Enter and clear together in S_B: clear wins, no ld_b
    btn_enter = 1'b1;
    btn_clear = 1'b1;
    tick(8);
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    tick(15);
    check("simul_state", 32'(state_code), 32'd0);

    // Run an OR calculation so op_latched is nonzero, then reach S_OP
    op_sel = 2'd3;
    exp_q.push_back(mk(3'b001, 2'd0, 3'd1));
    press_enter(8);
    exp_q.push_back(mk(3'b010, 2'd0, 3'd2));
    press_enter(8);
    exp_q.push_back(mk(3'b100, 2'd3, 3'd4));
    press_enter(8);
    drain("or_flow", 5);
    check("or_op", 32'(op_latched), 32'd3);
    press_enter(8);
    exp_q.push_back(mk(3'b001, 2'd3, 3'd1));
    press_enter(8);
    exp_q.push_back(mk(3'b010, 2'd3, 3'd2));
    press_enter(8);
    drain("pre_reset_flow", 5);
    check("pre_reset_state", 32'(state_code), 32'd2);

    // Partial-cycle async reset in S_OP
    #1 reset_n = 1'b0;
    #1;
    check("areset_state", 32'(state_code), 32'd0);
    check("areset_op", 32'(op_latched), 32'd0);
    check("areset_outs", 32'({ld_a, ld_b, ld_r, busy, done}), 32'd0);
    #1 reset_n = 1'b1;
    tick(2);
    check("post_reset_state", 32'(state_code), 32'd0);

    // Clear during EXEC on the ALU_LAT=8 instance
    for (int k = 0; k < 2; k++) begin
      enter8 = 1'b1;
      tick(8);
      enter8 = 1'b0;
      tick(15);
    end
    check("x8_state_op", 32'(state_code8), 32'd2);
    enter8 = 1'b1;
    for (int i = 0; i < 20 && !busy8; i++) tick(1);
    check("x8_busy_seen", 32'(busy8), 32'd1);
    check("x8_op", 32'(op_latched8), 32'd2);
    enter8 = 1'b0;
    clear8 = 1'b1;
    r0 = ldr8_total;
    tick(8);
    clear8 = 1'b0;
    tick(15);
    check("x8_clear_state", 32'(state_code8), 32'd0);
    check("x8_clear_op", 32'(op_latched8), 32'd0);
    check("x8_clear_busy", 32'({busy8, done8}), 32'd0);
    check("x8_no_ld_r", 32'(ldr8_total - r0), 32'd0);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
